// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, counter width and default cycle constants for the button path
package btn_pkg;
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;
  localparam int CNT_W = 32;
  localparam int unsigned DEB_20MS_20MHZ = 32'd400000;
  localparam int unsigned ONE_SEC_20MHZ  = 32'd20000000;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: multi-flop synchroniser for an asynchronous input, reset to a chosen idle level
module btn_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the raw level through the chain; the last flop is the settled copy
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ff <= {STAGES{RST_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and turn one push-button into press/release/long-press events and a toggle level
module btn_debounce
  import btn_pkg::*;
#(
  parameter int          SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_20MHZ,
  parameter int unsigned LONG_CYCLES     = ONE_SEC_20MHZ,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic toggle
);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic             sync_q;
  logic             s;
  logic             long_done;
  btn_sync #(.STAGES(SYNC_STAGES), .RST_VAL(~BTN_ACTIVE_HIGH)) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (btn_raw),
    .q   (sync_q)
  );
  // polarity-corrected pressed level, registered so the FSM sees a clean flop output
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) s <= 1'b0;
    else s <= sync_q ^ ~BTN_ACTIVE_HIGH;
  // debounce FSM with stability counter, hold counter and registered event outputs
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state       <= RELEASED;
      cnt         <= '0;
      hcnt        <= '0;
      btn_level   <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      long_done   <= 1'b0;
      toggle      <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      case (state)
        RELEASED:
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        PRESS_WAIT:
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            hcnt      <= '0;
            btn_level <= 1'b1;
            press     <= 1'b1;
            toggle    <= ~toggle;
            long_done <= 1'b0;
          end else cnt <= cnt + 1'b1;
        PRESSED: begin
          if (hcnt != LONG_MAX) hcnt <= hcnt + 1'b1;
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT:
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            hcnt        <= '0;
            btn_level   <= 1'b0;
            release_evt <= 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
      if ((state == PRESSED || state == RELEASE_WAIT) && hcnt == LONG_LAST && !long_done) begin
        long_press <= 1'b1;
        long_done  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for debounce latency, long press, bounce rejection, toggle and async reset
module tb_btn_debounce;
  typedef struct {
    int   kind;
    int   cyc;
    logic tog;
  } ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press, release_evt, long_press, toggle;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic exp_tog = 1'b0;
  ev_t  q[$];
  string nm[3] = '{"press", "release", "long_press"};
  btn_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .BTN_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press),
    .toggle     (toggle)
  );
  always #5 clk = ~clk;
  // scoreboard: every event pulse must match the oldest expected event in kind and cycle
  always @(posedge clk) begin
    logic [2:0] ev;
    ev_t e;
    cyc = cyc + 1;
    #1;
    ev = {long_press, release_evt, press};
    if (press || release_evt) begin
      n_tests++;
      if (press && release_evt) begin
        n_fail++;
        $display("FAIL excl: press and release both high at cycle %0d, required not both", cyc);
      end
    end
    for (int k = 0; k < 3; k++)
      if (ev[k]) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_%s: got unexpected %s at cycle %0d, required no event", nm[k], nm[k], cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL sb_%s: got %s at cycle %0d, required %s at cycle %0d", nm[k], nm[k], cyc, nm[e.kind], e.cyc);
          end else if (k == 0 && (toggle !== e.tog || btn_level !== 1'b1)) begin
            n_fail++;
            $display("FAIL sb_press_lvl: toggle=%b btn_level=%b, required toggle=%b btn_level=1", toggle, btn_level, e.tog);
          end else if (k == 1 && btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_release_lvl: btn_level=%b, required 0", btn_level);
          end
        end
      end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.tog  = exp_tog;
    q.push_back(e);
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    btn_raw = 1'b0;
    step(3);
    n_tests++;
    if ({btn_level, press, release_evt, long_press, toggle} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b, required 00000", {btn_level, press, release_evt, long_press, toggle});
    end
    rstn = 1'b1;
    step(5);
    n_tests++;
    if ({btn_level, toggle} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_release: level/toggle %b, required 00", {btn_level, toggle});
    end
  endtask
  task automatic test_glitch;
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    step(15);
    n_tests++;
    if (btn_level !== 1'b0 || toggle !== exp_tog) begin
      n_fail++;
      $display("FAIL glitch_lvl: btn_level=%b toggle=%b, required 0 %b", btn_level, toggle, exp_tog);
    end
  endtask
  task automatic test_clean_press;
    int n;
    n = cyc;
    btn_raw = 1'b1;
    exp_tog = ~exp_tog;
    push(0, n + 8);
    push(2, n + 18);
    step(7);
    n_tests++;
    if (btn_level !== 1'b0 || toggle !== ~exp_tog) begin
      n_fail++;
      $display("FAIL clean_early: btn_level=%b toggle=%b one edge before press, required 0 %b", btn_level, toggle, ~exp_tog);
    end
    step(1);
    n_tests++;
    if (btn_level !== 1'b1 || toggle !== exp_tog) begin
      n_fail++;
      $display("FAIL clean_level: btn_level=%b toggle=%b, required 1 %b", btn_level, toggle, exp_tog);
    end
    step(12);
    n = cyc;
    btn_raw = 1'b0;
    push(1, n + 8);
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL clean_drain: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    step(20);
  endtask
  task automatic test_long_press;
    int n;
    n = cyc;
    btn_raw = 1'b1;
    exp_tog = ~exp_tog;
    push(0, n + 8);
    push(2, n + 18);
    step(30);
    n = cyc;
    btn_raw = 1'b0;
    push(1, n + 8);
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL long_drain: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    step(20);
  endtask
  task automatic test_bouncy_release;
    int n;
    n = cyc;
    btn_raw = 1'b1;
    exp_tog = ~exp_tog;
    push(0, n + 8);
    push(2, n + 18);
    step(20);
    btn_raw = 1'b0;
    step(2);
    btn_raw = 1'b1;
    step(1);
    btn_raw = 1'b0;
    n = cyc;
    push(1, n + 8);
    step(5);
    n_tests++;
    if (btn_level !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_level: btn_level=%b during bounce, required 1", btn_level);
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_drain: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    step(20);
  endtask
  task automatic test_toggle;
    int n;
    for (int p = 0; p < 2; p++) begin
      n = cyc;
      btn_raw = 1'b1;
      exp_tog = ~exp_tog;
      push(0, n + 8);
      step(7);
      n_tests++;
      if (toggle !== ~exp_tog) begin
        n_fail++;
        $display("FAIL toggle_pre%0d: toggle=%b before press, required %b", p, toggle, ~exp_tog);
      end
      step(1);
      n_tests++;
      if (toggle !== exp_tog) begin
        n_fail++;
        $display("FAIL toggle_post%0d: toggle=%b at press, required %b", p, toggle, exp_tog);
      end
      step(2);
      n = cyc;
      btn_raw = 1'b0;
      push(1, n + 8);
      for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL toggle_drain%0d: %0d events outstanding, required 0", p, q.size());
        q.delete();
      end
      step(15);
    end
  endtask
  task automatic test_reset_mid;
    int n;
    btn_raw = 1'b1;
    step(4);
    #1 rstn = 1'b0;
    #1;
    n_tests++;
    if ({btn_level, press, release_evt, long_press, toggle} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_wait: outputs %b, required 00000", {btn_level, press, release_evt, long_press, toggle});
    end
    q.delete();
    exp_tog = 1'b0;
    step(2);
    rstn = 1'b1;
    n = cyc;
    exp_tog = 1'b1;
    push(0, n + 8);
    step(10);
    n_tests++;
    if (btn_level !== 1'b1 || toggle !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_repress: btn_level=%b toggle=%b pending=%0d, required 1 1 0", btn_level, toggle, q.size());
      q.delete();
    end
    #1 rstn = 1'b0;
    #1;
    n_tests++;
    if ({btn_level, press, release_evt, long_press, toggle} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_pressed: outputs %b, required 00000", {btn_level, press, release_evt, long_press, toggle});
    end
    exp_tog = 1'b0;
    step(2);
    rstn = 1'b1;
    n = cyc;
    exp_tog = 1'b1;
    push(0, n + 8);
    push(2, n + 18);
    step(25);
    n = cyc;
    btn_raw = 1'b0;
    push(1, n + 8);
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drain: %0d events outstanding, required 0", q.size());
      q.delete();
    end
    step(20);
  endtask
  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_long_press();
    test_bouncy_release();
    test_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
